// File: rtl/kl10_pkg.sv
// Shared KL10 datapath definitions: AD word width, double-word width and the
// long-add sequencer state encoding.
package kl10_pkg;

    localparam int AD_W  = 36;
    localparam int AD_DW = 2 * AD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } ad_long_state_t;

endpackage

// File: rtl/ad_long_seq.sv
// ad_long_seq: runs a 72-bit add/subtract through the shared 36-bit AD in two
// passes (low word, then high word), chaining the low carry-out into the high
// carry-in. The adder itself lives in EDP; this block only drives its operand
// selects and carry-in and captures its sum/carry.
// Bits are numbered [0:W-1] with bit 0 the MSB/sign, matching EDP.
// Optional build macro AD_LONG_FLAGS_EN adds registered cry0/cry1/ovf outputs.
//
// Handshake: start is sampled only in IDLE; there is no ready, a start seen
// outside IDLE is dropped. done pulses for one cycle when result_hi/result_lo
// are valid; flush aborts without done and leaves the result registers alone.
import kl10_pkg::*;

module ad_long_seq #(
    parameter int W = AD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sub,
    input  logic         cin_inh,
    input  logic         flush,
    input  logic [0:W-1] a_hi,
    input  logic [0:W-1] a_lo,
    input  logic [0:W-1] b_hi,
    input  logic [0:W-1] b_lo,
    input  logic [0:W-1] ad_sum,
    input  logic         ad_cout,
    output logic [0:W-1] ad_a,
    output logic [0:W-1] ad_b,
    output logic         ad_cin,
    output logic         adlong,
    output logic         busy,
    output logic         done,
    output logic [0:W-1] result_hi,
    output logic [0:W-1] result_lo,
    output logic [1:0]   state_dbg
`ifdef AD_LONG_FLAGS_EN
    ,
    output logic         cry0,
    output logic         cry1,
    output logic         ovf
`endif
);

    ad_long_state_t state;

    logic [0:W-1] a_hi_q, a_lo_q, b_hi_q, b_lo_q;
    logic         sub_q;
    logic         cin_inh_q;
    logic         cry_q;

    assign state_dbg = state;

    // AD operand/carry selects decoded from the registered state and operands.
    // Subtract feeds the inverted B word; the low pass injects the +1 unless
    // the PI-cycle inhibit is set, which leaves a one's-complement difference.
    always_comb begin
        ad_a   = '0;
        ad_b   = '0;
        ad_cin = 1'b0;
        case (state)
            LO: begin
                ad_a   = a_lo_q;
                ad_b   = b_lo_q ^ {W{sub_q}};
                ad_cin = sub_q & ~cin_inh_q;
            end
            HI: begin
                ad_a   = a_hi_q;
                ad_b   = b_hi_q ^ {W{sub_q}};
                ad_cin = cry_q;
            end
            default: ;
        endcase
    end

    // Sequencer FSM: operand latch, two AD passes, result capture and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_hi_q    <= '0;
            a_lo_q    <= '0;
            b_hi_q    <= '0;
            b_lo_q    <= '0;
            sub_q     <= 1'b0;
            cin_inh_q <= 1'b0;
            cry_q     <= 1'b0;
            adlong    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
`ifdef AD_LONG_FLAGS_EN
            cry0      <= 1'b0;
            cry1      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (flush) begin
                state  <= IDLE;
                adlong <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            a_hi_q    <= a_hi;
                            a_lo_q    <= a_lo;
                            b_hi_q    <= b_hi;
                            b_lo_q    <= b_lo;
                            sub_q     <= sub;
                            cin_inh_q <= cin_inh;
                            adlong    <= 1'b1;
                            busy      <= 1'b1;
                            state     <= LO;
`ifdef AD_LONG_FLAGS_EN
                            cry0      <= 1'b0;
                            cry1      <= 1'b0;
                            ovf       <= 1'b0;
`endif
                        end
                    end
                    LO: begin
                        result_lo <= ad_sum;
                        cry_q     <= ad_cout;
                        state     <= HI;
                    end
                    HI: begin
                        result_hi <= ad_sum;
                        adlong    <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
`ifdef AD_LONG_FLAGS_EN
                        // Carry into bit 0 is recovered from the sign-bit sum.
                        cry0      <= ad_cout;
                        cry1      <= ad_sum[0] ^ ad_a[0] ^ ad_b[0];
                        ovf       <= ad_cout ^ (ad_sum[0] ^ ad_a[0] ^ ad_b[0]);
`endif
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad_long_seq.sv
// Bench for ad_long_seq with a behavioural 36-bit AD wired to ad_a/ad_b/ad_cin.
// Expected 72-bit results come from whole-word arithmetic in the bench.
module tb_ad_long_seq;

    localparam int W = 36;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin_inh = 1'b0;
    logic         flush = 1'b0;
    logic [0:W-1] a_hi = '0, a_lo = '0, b_hi = '0, b_lo = '0;
    logic [0:W-1] ad_sum;
    logic         ad_cout;
    logic [0:W-1] ad_a, ad_b;
    logic         ad_cin, adlong, busy, done;
    logic [0:W-1] result_hi, result_lo;
    logic [1:0]   state_dbg;
`ifdef AD_LONG_FLAGS_EN
    logic         cry0, cry1, ovf;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [71:0] exp_q[$];
    logic [2:0]  flg_q[$];

    always #5 clk = ~clk;

    // Reference AD: plain 36-bit add with carry-in and carry-out.
    assign {ad_cout, ad_sum} = {1'b0, ad_a} + {1'b0, ad_b} + {36'd0, ad_cin};

    ad_long_seq #(.W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .cin_inh(cin_inh),
        .flush(flush), .a_hi(a_hi), .a_lo(a_lo), .b_hi(b_hi), .b_lo(b_lo),
        .ad_sum(ad_sum), .ad_cout(ad_cout), .ad_a(ad_a), .ad_b(ad_b),
        .ad_cin(ad_cin), .adlong(adlong), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .state_dbg(state_dbg)
`ifdef AD_LONG_FLAGS_EN
        , .cry0(cry0), .cry1(cry1), .ovf(ovf)
`endif
    );

    function automatic logic [71:0] model_result(input logic [35:0] ah, al, bh, bl,
                                                 input logic s, ci);
        logic [71:0] a, b;
        a = {ah, al};
        b = {bh, bl};
        if (s) b = ~b;
        return a + b + {71'd0, s & ~ci};
    endfunction

    // {cry0, cry1, ovf} of the high pass.
    function automatic logic [2:0] model_flags(input logic [35:0] ah, al, bh, bl,
                                               input logic s, ci);
        logic [35:0] bhx, blx;
        logic [36:0] lo37, hi37;
        logic [35:0] low35;
        logic        c, c0, c1;
        bhx   = s ? ~bh : bh;
        blx   = s ? ~bl : bl;
        lo37  = {1'b0, al} + {1'b0, blx} + {36'd0, s & ~ci};
        c     = lo37[36];
        hi37  = {1'b0, ah} + {1'b0, bhx} + {36'd0, c};
        low35 = {1'b0, ah[34:0]} + {1'b0, bhx[34:0]} + {35'd0, c};
        c0    = hi37[36];
        c1    = low35[35];
        return {c0, c1, c0 ^ c1};
    endfunction

    function automatic logic [35:0] rand36();
        logic [35:0] v;
        v[31:0]  = $urandom;
        v[35:32] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    // One complete operation: drive, push expectation, wait for done, compare.
    task automatic run_op(input logic [35:0] ah, al, bh, bl, input logic s, ci,
                          input string name);
        int          cyc;
        bit          got;
        logic [71:0] exp_r;
        logic [2:0]  exp_f;
        @(negedge clk);
        a_hi = ah; a_lo = al; b_hi = bh; b_lo = bl;
        sub = s; cin_inh = ci; start = 1'b1;
        exp_q.push_back(model_result(ah, al, bh, bl, s, ci));
        flg_q.push_back(model_flags(ah, al, bh, bl, s, ci));
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, adlong} !== 2'b11) begin
            n_fail++;
            $display("FAIL %s lo_status: busy/adlong=%b required 11", name, {busy, adlong});
        end
        n_checks++;
        if (ad_cin !== (s & ~ci) || ad_a !== al) begin
            n_fail++;
            $display("FAIL %s lo_operands: ad_cin=%b ad_a=%h required %b %h",
                     name, ad_cin, ad_a, s & ~ci, al);
        end
        cyc = 1;
        got = 0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) got = 1;
        end
        exp_r = exp_q.pop_front();
        exp_f = flg_q.pop_front();
        n_checks++;
        if (!got || cyc != 3) begin
            n_fail++;
            $display("FAIL %s latency: done seen=%0d after %0d edges, required after 3", name, got, cyc);
        end
        n_checks++;
        if ({result_hi, result_lo} !== exp_r) begin
            n_fail++;
            $display("FAIL %s result: got %h_%h required %h_%h", name, result_hi, result_lo,
                     exp_r[71:36], exp_r[35:0]);
        end
`ifdef AD_LONG_FLAGS_EN
        n_checks++;
        if ({cry0, cry1, ovf} !== exp_f) begin
            n_fail++;
            $display("FAIL %s flags: cry0/cry1/ovf=%b required %b", name, {cry0, cry1, ovf}, exp_f);
        end
`endif
        @(negedge clk);
        n_checks++;
        if ({busy, done, adlong} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s idle_after: busy/done/adlong=%b required 000", name, {busy, done, adlong});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, adlong, ad_cin} !== 4'b0000 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_status: busy/done/adlong/cin=%b state=%0d required 0000 0",
                     {busy, done, adlong, ad_cin}, state_dbg);
        end
        n_checks++;
        if ({result_hi, result_lo, ad_a, ad_b} !== 144'd0) begin
            n_fail++;
            $display("FAIL reset_data: res=%h_%h ad_a=%h ad_b=%h required all 0",
                     result_hi, result_lo, ad_a, ad_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_carry();
        run_op(36'h0, 36'hFFFFFFFFF, 36'h0, 36'h1, 1'b0, 1'b0, "carry");
    endtask

    task automatic test_sub();
        run_op(36'h1, 36'h0, 36'h0, 36'h1, 1'b1, 1'b0, "sub");
        n_checks++;
        if (result_hi !== 36'h0 || result_lo !== 36'hFFFFFFFFF) begin
            n_fail++;
            $display("FAIL sub_const: got %h_%h required 000000000_fffffffff", result_hi, result_lo);
        end
    endtask

    task automatic test_cin_inh();
        run_op(36'h0, 36'h5, 36'h0, 36'h3, 1'b1, 1'b1, "cin_inh");
        n_checks++;
        if (result_lo !== 36'h1) begin
            n_fail++;
            $display("FAIL cin_inh_const: result_lo=%h required 000000001", result_lo);
        end
    endtask

    task automatic test_flags();
        // Max positive high word plus one overflows into the sign bit.
        run_op(36'h7FFFFFFFF, 36'h0, 36'h1, 36'h0, 1'b0, 1'b0, "flags_ovf");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            run_op(rand36(), rand36(), rand36(), rand36(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), "random");
    endtask

    task automatic test_flush();
        bit seen_done;
        run_op(36'h123, 36'h0AA, 36'h0, 36'h0, 1'b0, 1'b0, "pre_flush");
        @(negedge clk);
        a_hi = 36'h456; a_lo = 36'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || state_dbg !== 2'd0 || result_hi !== 36'h123) begin
            n_fail++;
            $display("FAIL flush_hi: busy=%b state=%0d result_hi=%h required 0 0 000000123",
                     busy, state_dbg, result_hi);
        end
        seen_done = (done === 1'b1);
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL flush_no_done: done pulse seen=1 required 0");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_hi = 36'h777; a_lo = 36'h2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, adlong} !== 2'b00 || {result_hi, result_lo} !== 72'd0 || ad_a !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy/adlong=%b res=%h_%h ad_a=%h required 00 0 0",
                     {busy, adlong}, result_hi, result_lo, ad_a);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [71:0] exp_r;
        @(negedge clk);
        a_hi = 36'h0; a_lo = 36'h10; b_hi = 36'h0; b_lo = 36'h20;
        sub = 1'b0; cin_inh = 1'b0; start = 1'b1;
        exp_q.push_back(model_result(36'h0, 36'h10, 36'h0, 36'h20, 1'b0, 1'b0));
        exp_q.push_back(model_result(36'h9, 36'h1, 36'h0, 36'h3, 1'b1, 1'b0));
        exp_q.push_back(model_result(36'h9, 36'h1, 36'h0, 36'h3, 1'b1, 1'b0));
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Changed while LO is running; must only affect the next accept.
                a_hi = 36'h9; a_lo = 36'h1; b_lo = 36'h3; sub = 1'b1;
            end
            if (k == 12) start = 1'b0;
            n_checks++;
            if (done !== ((k % 4) == 3)) begin
                n_fail++;
                $display("FAIL b2b_done_k%0d: done=%b required %b", k, done, (k % 4) == 3);
            end
            if (done === 1'b1 && exp_q.size() > 0) begin
                exp_r = exp_q.pop_front();
                n_checks++;
                if ({result_hi, result_lo} !== exp_r) begin
                    n_fail++;
                    $display("FAIL b2b_result_k%0d: got %h_%h required %h_%h", k,
                             result_hi, result_lo, exp_r[71:36], exp_r[35:0]);
                end
            end
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: busy=%b pending=%0d required 0 0", busy, exp_q.size());
        end
        exp_q.delete();
        sub = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_carry();
        test_sub();
        test_cin_inh();
        test_flags();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
